// File: rtl/mem_req_adapter.sv
// Load/store request adapter in front of the 2-way D-cache.
// Holds one request stable until accepted, then returns extended load data or a store ack.
module mem_req_adapter #(
    parameter int ERR_NO_CACHE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_adel,
    output logic        resp_ades,
    output logic        valid,
    output logic        op,
    output logic [7:0]  index,
    output logic [19:0] tag,
    output logic [3:0]  offset,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic        adel_q;
    logic        ades_q;

    logic        misalign;
    logic        err_en;
    logic [31:0] ext_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  strb;

    assign err_en = (ERR_NO_CACHE != 0);

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = req_addr[0];
            default: misalign = |req_addr[1:0];
        endcase
        misalign = misalign & err_en;
    end

    // Extract and extend the addressed lane of the returned cache word.
    always_comb begin
        byte_sel = rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    ext_d = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'd1:    ext_d = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: ext_d = rdata;
        endcase
        if (we_q) begin
            ext_d = 32'h0;
        end
    end

    always_comb begin
        strb = 4'b0000;
        if (we_q) begin
            case (size_q)
                2'd0:    strb = 4'b0001 << addr_q[1:0];
                2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
                default: strb = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        rdata_q <= 32'h0;
                        adel_q  <= misalign & ~req_we;
                        ades_q  <= misalign & req_we;
                        state_q <= misalign ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (addr_ok) begin
                        if (data_ok) begin
                            rdata_q <= ext_d;
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (data_ok) begin
                        rdata_q <= ext_d;
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign valid      = (state_q == REQ);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_adel  = adel_q;
    assign resp_ades  = ades_q;
    assign op         = we_q;
    assign index      = addr_q[11:4];
    assign tag        = addr_q[31:12];
    assign offset     = addr_q[3:0];
    assign wstrb      = strb;
    assign wdata      = wdata_q;

endmodule

// File: tb/tb_mem_req_adapter.sv
// Directed bench for mem_req_adapter with a per-cycle checker against a
// behavioural request/response model.
module tb_mem_req_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_adel, resp_ades;
    logic [31:0] resp_rdata;
    logic        valid, op;
    logic [7:0]  index;
    logic [19:0] tag;
    logic [3:0]  offset, wstrb;
    logic [31:0] wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int n_chk = 0;
    int n_fail = 0;

    logic        active = 1'b0;
    logic        cur_we, cur_uns;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wd, cur_word;
    int          resp_cnt;

    mem_req_adapter #(.ERR_NO_CACHE(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_adel(resp_adel), .resp_ades(resp_ades),
        .valid(valid), .op(op), .index(index), .tag(tag),
        .offset(offset), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [1:0] s, input logic [31:0] a);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic we, input logic [1:0] s,
                                          input logic [31:0] a);
        int m;
        if (!we) return 4'd0;
        m = ((1 << nbytes(s)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] s, input logic uns,
                                           input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int n;
        n = nbytes(s);
        if (n == 4) return w;
        v = (w >> (8 * (a % 4))) & ((32'd1 << (8 * n)) - 1);
        if (!uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of cache request and response against the model.
    always @(negedge clk) begin
        if (active && !reset) begin
            if (valid) begin
                chk("mis_no_cache", 32'(is_mis(cur_size, cur_addr)), 32'd0);
                chk("op", 32'(op), 32'(cur_we));
                chk("tag", 32'(tag), cur_addr / 4096);
                chk("index", 32'(index), (cur_addr / 16) % 256);
                chk("offset", 32'(offset), cur_addr % 16);
                chk("wstrb", 32'(wstrb), 32'(m_strb(cur_we, cur_size, cur_addr)));
                chk("wdata", wdata, cur_wd);
            end
            if (resp_valid) begin
                resp_cnt++;
                chk("resp_adel", 32'(resp_adel),
                    32'(is_mis(cur_size, cur_addr) && !cur_we));
                chk("resp_ades", 32'(resp_ades),
                    32'(is_mis(cur_size, cur_addr) && cur_we));
                chk("resp_rdata", resp_rdata,
                    (cur_we || is_mis(cur_size, cur_addr)) ? 32'h0 :
                    m_load(cur_size, cur_uns, cur_addr, cur_word));
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] word, input int miss, input logic split,
                       input logic [31:0] lit, input logic [3:0] lit_strb);
        cur_we = we; cur_size = size; cur_uns = uns;
        cur_addr = addr; cur_wd = wd; cur_word = word;
        resp_cnt = 0;
        active = 1'b1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (is_mis(size, addr)) begin
            @(negedge clk);
            chk("mis_resp_c1", 32'(resp_valid), 32'd1);
            chk("mis_valid", 32'(valid), 32'd0);
            @(posedge clk); #1;
        end else begin
            // Ignored requests while busy must not disturb held fields.
            req_valid = (miss > 0); req_addr = 32'hFFFF_FFF0; req_we = ~we;
            for (int i = 0; i < miss; i++) begin
                @(negedge clk);
                chk("miss_valid_held", 32'(valid), 32'd1);
                chk("miss_no_ready", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            addr_ok = 1'b1; data_ok = !split;
            rdata = split ? 32'h5A5A_5A5A : word;
            @(negedge clk);
            chk("valid_at_accept", 32'(valid), 32'd1);
            chk("strb_literal", 32'(wstrb), 32'(lit_strb));
            @(posedge clk); #1;
            addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
            if (split) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("wait_valid_low", 32'(valid), 32'd0);
                    chk("wait_no_resp", 32'(resp_valid), 32'd0);
                    @(posedge clk); #1;
                end
                data_ok = 1'b1; rdata = word;
                @(posedge clk); #1;
                data_ok = 1'b0; rdata = 32'h0;
            end
            @(negedge clk);
            chk("resp_latency", 32'(resp_valid), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
        chk("resp_count", 32'(resp_cnt), 32'd1);
        chk("rdata_literal_held", resp_rdata, lit);
        active = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; addr_ok = 0; data_ok = 0; rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_flags", {30'd0, resp_adel, resp_ades}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        txn(0, 2'd2, 0, 32'h0000_1230, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 4'h0);
        txn(0, 2'd0, 0, 32'h0000_1233, 32'h0, 32'h80FF_0000, 0, 0, 32'hFFFF_FF80, 4'h0);
        txn(0, 2'd0, 1, 32'h0000_1233, 32'h0, 32'h80FF_0000, 0, 0, 32'h0000_0080, 4'h0);
        txn(1, 2'd1, 0, 32'h0000_1232, 32'h0000_ABCD, 32'h0, 0, 0, 32'h0, 4'b1100);
        txn(1, 2'd0, 0, 32'h0000_1231, 32'h0000_0055, 32'h0, 0, 0, 32'h0, 4'b0010);
        txn(0, 2'd3, 0, 32'hABCD_5670, 32'h0, 32'h1357_9BDF, 20, 0, 32'h1357_9BDF, 4'h0);
        txn(0, 2'd1, 1, 32'h0000_2002, 32'h0, 32'h1234_8765, 2, 1, 32'h0000_1234, 4'h0);
        txn(0, 2'd1, 0, 32'h0000_2000, 32'h0, 32'h0000_9ABC, 0, 1, 32'hFFFF_9ABC, 4'h0);
        txn(0, 2'd2, 0, 32'h0000_1232, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0);
        chk("adel_lit", 32'(resp_adel), 32'd1);
        txn(1, 2'd1, 0, 32'h0000_1231, 32'h1111, 32'h0, 0, 0, 32'h0, 4'h0);
        chk("ades_lit", 32'(resp_ades), 32'd1);

        // Reset in REQ aborts; a late cache response must be dropped.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_3330;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_data_no_resp", 32'(resp_valid), 32'd0);
            chk("late_data_no_valid", 32'(valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
